// File: rtl/tm_buffer_reader.sv
// Drains Tm output-channel buffers in pixel-major order into a ready/valid stream.
// One-cycle buffer latency is absorbed by a 2-entry skid FIFO, so backpressure never drops a word.
module tm_buffer_reader #(
  parameter int Tm            = 8,
  parameter int FEATURE_WIDTH = 16,
  parameter int ADDR_WIDTH    = 10,
  localparam int CW           = $clog2(Tm)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH:0]         pixel_count,
  output logic [Tm-1:0]               buf_enb,
  output logic [ADDR_WIDTH-1:0]       buf_addrb,
  input  logic [Tm*FEATURE_WIDTH-1:0] buf_dob,
  output logic [FEATURE_WIDTH-1:0]    out_data,
  output logic [CW-1:0]               out_channel,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [FEATURE_WIDTH-1:0] data;
    logic [CW-1:0]            ch;
    logic [ADDR_WIDTH-1:0]    addr;
  } entry_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   pix_q, pix_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [CW-1:0]         rd_ch_q, rd_ch_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  entry_t                slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  pop, push, issue, want_rd, room, last;
  logic [2:0]            occ;
  logic [CW-1:0]         cur_ch;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   cur_pix;
  entry_t                new_e;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    pix_d     = pix_q;
    rd_vld_d  = 1'b0;
    rd_ch_d   = rd_ch_q;
    rd_addr_d = rd_addr_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    cnt_d     = cnt_q;
    buf_enb   = '0;
    buf_addrb = '0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    // The first read goes out in the start cycle itself, from position (0,0).
    cur_ch   = (state_q == IDLE) ? '0 : ch_q;
    cur_addr = (state_q == IDLE) ? '0 : addr_q;
    cur_pix  = (state_q == IDLE) ? pixel_count : pix_q;
    last     = (cur_ch == CW'(Tm-1)) && ({1'b0, cur_addr} == cur_pix - 1'b1);

    pop  = (cnt_q != 2'd0) && out_ready;
    push = rd_vld_q;
    // Occupancy after this cycle's pop, counting the read already in flight.
    occ  = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
    room = (occ < 3'd2) && (cnt_q != 2'd2);

    want_rd = (state_q == READ) ||
              (state_q == IDLE && start && pixel_count != '0);
    issue   = want_rd && room && !rst;

    if (issue) begin
      buf_enb   = Tm'(1) << cur_ch;
      buf_addrb = cur_addr;
      rd_vld_d  = 1'b1;
      rd_ch_d   = cur_ch;
      rd_addr_d = cur_addr;
      if (!last) begin
        if (cur_ch == CW'(Tm-1)) begin
          ch_d   = '0;
          addr_d = cur_addr + 1'b1;
        end else begin
          ch_d   = cur_ch + 1'b1;
          addr_d = cur_addr;
        end
      end
    end

    new_e.data = buf_dob[int'(rd_ch_q)*FEATURE_WIDTH +: FEATURE_WIDTH];
    new_e.ch   = rd_ch_q;
    new_e.addr = rd_addr_q;

    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = new_e;
        else               slot1_d = new_e;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) slot0_d = new_e;
        else begin
          slot0_d = slot1_q;
          slot1_d = new_e;
        end
      end
      default: ;
    endcase

    case (state_q)
      IDLE: if (start) begin
        pix_d = pixel_count;
        if (pixel_count == '0) state_d = DONE;
        else if (issue && last) state_d = DRAIN;
        else state_d = READ;
      end
      READ:  if (issue && last) state_d = DRAIN;
      DRAIN: if (cnt_d == 2'd0 && !rd_vld_d) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      addr_q    <= '0;
      pix_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_ch_q   <= '0;
      rd_addr_q <= '0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      pix_q     <= pix_d;
      rd_vld_q  <= rd_vld_d;
      rd_ch_q   <= rd_ch_d;
      rd_addr_q <= rd_addr_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = (cnt_q != 2'd0);
  assign out_data    = slot0_q.data;
  assign out_channel = slot0_q.ch;
  assign out_addr    = slot0_q.addr;

endmodule
